// File: rtl/sdram_responder.sv
// sdram_responder: device-side model of an SDR x16 SDRAM.
// Decodes the command bus from sdram_controller and tracks which row is
// open in each bank. Data lives in a small internal array. Read data
// comes back after the programmed CAS latency. Protocol violations are
// latched into sticky error flags that only rst clears.
module sdram_responder #(
  parameter int ROW_WIDTH      = 13,
  parameter int COL_WIDTH      = 9,
  parameter int BANK_WIDTH     = 2,
  parameter int MEM_AW         = 12,
  parameter int REF_MAX_CYCLES = 512,
  localparam int ADDR_WIDTH    = (ROW_WIDTH > COL_WIDTH) ? ROW_WIDTH : COL_WIDTH,
  localparam int NUM_BANKS     = 1 << BANK_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clock_enable,
  input  logic                  cs_n,
  input  logic                  ras_n,
  input  logic                  cas_n,
  input  logic                  we_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [BANK_WIDTH-1:0] bank_addr,
  input  logic [15:0]           dq_in,
  input  logic                  dq_in_en,
  input  logic                  data_mask_low,
  input  logic                  data_mask_high,
  output logic [15:0]           dq_out,
  output logic                  dq_out_en,
  output logic                  mode_set,
  output logic [2:0]            cas_latency,
  output logic [NUM_BANKS-1:0]  bank_open,
  output logic [15:0]           refresh_count,
  output logic [6:0]            err
);

  localparam int              A10_BIT  = 10;
  localparam int              WD_W     = $clog2(REF_MAX_CYCLES + 2);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(REF_MAX_CYCLES);
  localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1'b1);

  // Command encodings as {ras_n, cas_n, we_n}. 110 is a burst stop, which
  // this model treats as a NOP.
  typedef enum logic [2:0] {
    CMD_MRS   = 3'b000,
    CMD_REF   = 3'b001,
    CMD_PRE   = 3'b010,
    CMD_ACT   = 3'b011,
    CMD_WRITE = 3'b100,
    CMD_READ  = 3'b101,
    CMD_BST   = 3'b110,
    CMD_NOP   = 3'b111
  } cmd_e;

  // Only CL2 and CL3 are supported. Any other programmed value is an error.
  function automatic logic cl_supported(input logic [2:0] cl);
    return (cl == 3'd2) || (cl == 3'd3);
  endfunction

  cmd_e                  cmd_s;
  logic                  bank_hit_s;
  logic                  rd_fire_s;
  logic                  wr_fire_s;
  logic [ROW_WIDTH-1:0]  row_s;
  logic [MEM_AW-1:0]     mem_idx_s;
  logic [15:0]           rd_data_s;
  logic [6:0]            err_set_s;
  logic [WD_W-1:0]       wd_next_s;
  logic                  out_valid_s;
  logic [15:0]           out_data_s;

  logic [ROW_WIDTH-1:0]  open_row_r [NUM_BANKS];
  logic [NUM_BANKS-1:0]  bank_open_r;
  logic [15:0]           mem_r [0:(1 << MEM_AW)-1];
  logic                  mode_set_r;
  logic [2:0]            cl_r;
  logic [15:0]           refresh_count_r;
  logic [WD_W-1:0]       wd_r;
  logic [6:0]            err_r;
  logic                  s0_valid_r;
  logic                  s0_cl2_r;
  logic [15:0]           s0_data_r;
  logic                  s1_valid_r;
  logic [15:0]           s1_data_r;
  logic [15:0]           dq_out_r;
  logic                  dq_out_en_r;

  // Decode the pins into a command. A deselected or clock-disabled cycle is a NOP.
  always_comb begin
    cmd_s = CMD_NOP;
    if (clock_enable && !cs_n) begin
      cmd_s = cmd_e'({ras_n, cas_n, we_n});
    end else begin
      cmd_s = CMD_NOP;
    end
  end

  // Accesses use the row latched at ACT. The array index folds {bank,row,col} down to MEM_AW bits.
  assign row_s      = open_row_r[bank_addr];
  assign mem_idx_s  = MEM_AW'({bank_addr, row_s, addr[COL_WIDTH-1:0]});
  assign bank_hit_s = bank_open_r[bank_addr];
  assign rd_fire_s  = (cmd_s == CMD_READ)  && bank_hit_s;
  assign wr_fire_s  = (cmd_s == CMD_WRITE) && bank_hit_s;
  assign rd_data_s  = mem_r[mem_idx_s];

  // Track the open row and the active flag of each bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_open_r <= '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
        open_row_r[i] <= '0;
      end
    end else begin
      case (cmd_s)
        CMD_ACT: begin
          open_row_r[bank_addr]  <= addr[ROW_WIDTH-1:0];
          bank_open_r[bank_addr] <= 1'b1;
        end
        CMD_READ, CMD_WRITE: begin
          if (bank_hit_s && addr[A10_BIT]) begin
            bank_open_r[bank_addr] <= 1'b0;
          end
        end
        CMD_PRE: begin
          if (addr[A10_BIT]) begin
            bank_open_r <= '0;
          end else begin
            bank_open_r[bank_addr] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Byte-masked write into the array. The array contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      if (!data_mask_low) begin
        mem_r[mem_idx_s][7:0] <= dq_in[7:0];
      end
      if (!data_mask_high) begin
        mem_r[mem_idx_s][15:8] <= dq_in[15:8];
      end
    end
  end

  // Mode register: programs the CAS latency and falls back to CL3 on an unsupported value.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_set_r <= 1'b0;
      cl_r       <= 3'd3;
    end else if (cmd_s == CMD_MRS) begin
      mode_set_r <= 1'b1;
      cl_r       <= cl_supported(addr[6:4]) ? addr[6:4] : 3'd3;
    end
  end

  // Watchdog next value: a REF clears it. Otherwise it counts while the mode is set and saturates past the limit.
  always_comb begin
    wd_next_s = wd_r;
    if (cmd_s == CMD_REF) begin
      wd_next_s = '0;
    end else if (mode_set_r && (wd_r <= WD_LIMIT)) begin
      wd_next_s = wd_r + WD_ONE;
    end else begin
      wd_next_s = wd_r;
    end
  end

  // Refresh counter, saturating at 0xFFFF, and the refresh watchdog register.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_count_r <= 16'd0;
      wd_r            <= '0;
    end else begin
      wd_r <= wd_next_s;
      if ((cmd_s == CMD_REF) && (refresh_count_r != 16'hFFFF)) begin
        refresh_count_r <= refresh_count_r + 16'd1;
      end
    end
  end

  // Protocol violations detected on this edge.
  always_comb begin
    err_set_s    = 7'd0;
    err_set_s[0] = ((cmd_s == CMD_READ) || (cmd_s == CMD_WRITE)) && !bank_hit_s;
    err_set_s[1] = (cmd_s == CMD_ACT) && bank_hit_s;
    err_set_s[2] = ((cmd_s == CMD_ACT) || (cmd_s == CMD_READ) || (cmd_s == CMD_WRITE))
                   && !mode_set_r;
    err_set_s[3] = (cmd_s == CMD_REF) && (|bank_open_r);
    err_set_s[4] = (cmd_s == CMD_MRS) && !cl_supported(addr[6:4]);
    err_set_s[5] = (wd_next_s > WD_LIMIT);
    err_set_s[6] = (cmd_s == CMD_WRITE) && !dq_in_en;
  end

  // Sticky error flags. Only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 7'd0;
    end else begin
      err_r <= err_r | err_set_s;
    end
  end

  // Read-latency pipeline. Each entry carries the CL it was issued with, so a later MRS does not disturb reads in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_r <= 1'b0;
      s0_cl2_r   <= 1'b0;
      s0_data_r  <= 16'd0;
      s1_valid_r <= 1'b0;
      s1_data_r  <= 16'd0;
    end else begin
      s0_valid_r <= rd_fire_s;
      s0_cl2_r   <= (cl_r == 3'd2);
      s0_data_r  <= rd_fire_s ? rd_data_s : 16'd0;
      s1_valid_r <= s0_valid_r && !s0_cl2_r;
      s1_data_r  <= s0_data_r;
    end
  end

  // Two reads cannot come due together: an MRS between them always costs an edge. Stage 1 still wins for determinism.
  always_comb begin
    out_valid_s = s1_valid_r || (s0_valid_r && s0_cl2_r);
    out_data_s  = s0_data_r;
    if (s1_valid_r) begin
      out_data_s = s1_data_r;
    end else begin
      out_data_s = s0_data_r;
    end
  end

  // Registered read-data outputs. The word holds after its one-cycle valid strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      dq_out_r    <= 16'd0;
      dq_out_en_r <= 1'b0;
    end else begin
      dq_out_en_r <= out_valid_s;
      if (out_valid_s) begin
        dq_out_r <= out_data_s;
      end
    end
  end

  assign dq_out        = dq_out_r;
  assign dq_out_en     = dq_out_en_r;
  assign mode_set      = mode_set_r;
  assign cas_latency   = cl_r;
  assign bank_open     = bank_open_r;
  assign refresh_count = refresh_count_r;
  assign err           = err_r;

endmodule

// File: tb/tb_sdram_responder.sv
// Testbench for sdram_responder: directed protocol scenarios plus
// randomized command traffic, checked against a transaction-level model.
module tb_sdram_responder;

  localparam int REF_MAX = 512;
  localparam logic [2:0] C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011,
                         C_WR  = 3'b100, C_RD  = 3'b101, C_NOP = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clock_enable = 1'b1;
  logic        cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [12:0] addr = 13'd0;
  logic [1:0]  bank_addr = 2'd0;
  logic [15:0] dq_in = 16'd0;
  logic        dq_in_en = 1'b0, data_mask_low = 1'b0, data_mask_high = 1'b0;
  logic [15:0] dq_out;
  logic        dq_out_en, mode_set;
  logic [2:0]  cas_latency;
  logic [3:0]  bank_open;
  logic [15:0] refresh_count;
  logic [6:0]  err;

  sdram_responder dut (
    .clk(clk), .rst(rst), .clock_enable(clock_enable), .cs_n(cs_n), .ras_n(ras_n),
    .cas_n(cas_n), .we_n(we_n), .addr(addr), .bank_addr(bank_addr), .dq_in(dq_in),
    .dq_in_en(dq_in_en), .data_mask_low(data_mask_low), .data_mask_high(data_mask_high),
    .dq_out(dq_out), .dq_out_en(dq_out_en), .mode_set(mode_set), .cas_latency(cas_latency),
    .bank_open(bank_open), .refresh_count(refresh_count), .err(err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int ecnt     = 0;

  // Reference model: device state kept as plain variables plus a queue of expected read returns.
  typedef struct { int due; logic [15:0] data; } rd_t;
  logic [15:0] m_mem [int];
  logic [12:0] m_row [4];
  logic [3:0]  m_open;
  bit          m_mode;
  int          m_cl, m_ref, m_wd_start;
  logic [6:0]  m_err;
  rd_t         m_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_open = 4'd0; m_mode = 1'b0; m_cl = 3; m_ref = 0; m_err = 7'd0;
    m_wd_start = ecnt; m_q.delete();
  endtask

  task automatic model_step(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                            input logic [15:0] d, input logic ml, input logic mh,
                            input logic en, input logic csn);
    logic [2:0]  cc;
    logic [23:0] full;
    int          idx;
    logic [15:0] w;
    rd_t         e;
    cc = csn ? C_NOP : c;
    case (cc)
      C_ACT: begin
        if (!m_mode) m_err[2] = 1'b1;
        if (m_open[b]) m_err[1] = 1'b1;
        m_row[b] = a; m_open[b] = 1'b1;
      end
      C_RD, C_WR: begin
        if (!m_mode) m_err[2] = 1'b1;
        if (cc == C_WR && !en) m_err[6] = 1'b1;
        if (!m_open[b]) m_err[0] = 1'b1;
        else begin
          full = {b, m_row[b], a[8:0]};
          idx  = int'(full[11:0]);
          if (cc == C_WR) begin
            w = m_mem.exists(idx) ? m_mem[idx] : 16'hxxxx;
            if (!ml) w[7:0]  = d[7:0];
            if (!mh) w[15:8] = d[15:8];
            m_mem[idx] = w;
          end else begin
            e.due  = ecnt + m_cl - 1;
            e.data = m_mem.exists(idx) ? m_mem[idx] : 16'hxxxx;
            m_q.push_back(e);
          end
          if (a[10]) m_open[b] = 1'b0;
        end
      end
      C_PRE: if (a[10]) m_open = 4'd0; else m_open[b] = 1'b0;
      C_REF: begin
        if (|m_open) m_err[3] = 1'b1;
        if (m_ref < 65535) m_ref++;
        m_wd_start = ecnt;
      end
      C_MRS: begin
        if (!m_mode) m_wd_start = ecnt;
        m_mode = 1'b1;
        if (a[6:4] == 3'd2 || a[6:4] == 3'd3) m_cl = int'(a[6:4]);
        else begin m_cl = 3; m_err[4] = 1'b1; end
      end
      default: ;
    endcase
    if (m_mode && (ecnt - m_wd_start) > REF_MAX) m_err[5] = 1'b1;
  endtask

  // Per-cycle check of the read strobe, read data and bank flags.
  task automatic check_cycle();
    bit  exp_en;
    rd_t e;
    exp_en = (m_q.size() > 0) && (m_q[0].due == ecnt);
    chk("dq_out_en", dq_out_en, exp_en);
    if (exp_en) begin
      e = m_q.pop_front();
      if (!$isunknown(e.data)) chk("dq_out", dq_out, e.data);
    end
    chk("bank_open", bank_open, m_open);
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".mode_set"}, mode_set, m_mode);
    chk({tag, ".cas_latency"}, cas_latency, m_cl);
    chk({tag, ".refresh_count"}, refresh_count, m_ref);
    chk({tag, ".err"}, err, m_err);
  endtask

  task automatic cmd(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                     input logic [15:0] d, input logic ml, input logic mh,
                     input logic en, input logic csn);
    cs_n = csn; {ras_n, cas_n, we_n} = c; bank_addr = b; addr = a; dq_in = d;
    data_mask_low = ml; data_mask_high = mh; dq_in_en = en;
    @(posedge clk);
    ecnt++;
    model_step(c, b, a, d, ml, mh, en, csn);
    #1;
    check_cycle();
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cmd(C_NOP, 2'd0, 13'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic act(input logic [1:0] b, input logic [12:0] r);
    cmd(C_ACT, b, r, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic wr(input logic [1:0] b, input logic [12:0] a, input logic [15:0] d,
                    input logic ml, input logic mh);
    cmd(C_WR, b, a, d, ml, mh, 1'b1, 1'b0);
  endtask
  task automatic rd(input logic [1:0] b, input logic [12:0] a);
    cmd(C_RD, b, a, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic mrs(input logic [12:0] a);
    cmd(C_MRS, 2'd0, a, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_cycle();
    rst = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = C_NOP; dq_in_en = 1'b0;
    @(posedge clk);
    ecnt++;
    model_reset();
    #1;
    check_cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0]  b;
    logic [2:0]  rc;
    logic [12:0] a;
    int          r;

    // Reset values.
    reset_cycle();
    reset_cycle();
    check_state("reset");
    chk("reset.dq_out", dq_out, 16'h0000);
    chk("reset.cas_latency_const", cas_latency, 3'd3);

    // Mode register: valid CL3, then an unsupported CL.
    mrs(13'h030);
    check_state("mrs3");
    chk("mrs3.err_const", err, 7'd0);
    mrs(13'h050);
    check_state("mrs5");
    chk("mrs5.err4", err[4], 1'b1);
    chk("mrs5.cl", cas_latency, 3'd3);

    // Write with auto-precharge, reopen, read with auto-precharge.
    reset_cycle();
    mrs(13'h030);
    act(2'd1, 13'h0123);
    wr(2'd1, 13'h0445, 16'hA5C3, 1'b0, 1'b0);
    act(2'd1, 13'h0123);
    rd(2'd1, 13'h0445);
    chk("autopre.bank1", bank_open[1], 1'b0);
    nop(1);
    chk("rd.T+1.en", dq_out_en, 1'b0);
    nop(1);
    chk("rd.T+2.en", dq_out_en, 1'b1);
    chk("rd.T+2.data", dq_out, 16'hA5C3);
    nop(1);
    chk("rd.T+3.en", dq_out_en, 1'b0);

    // Byte masks.
    act(2'd0, 13'h0005);
    wr(2'd0, 13'h0007, 16'hFFFF, 1'b0, 1'b0);
    wr(2'd0, 13'h0007, 16'h1234, 1'b0, 1'b1);
    rd(2'd0, 13'h0007);
    nop(2);
    chk("mask_high.data", dq_out, 16'hFF34);
    wr(2'd0, 13'h0007, 16'hFFFF, 1'b0, 1'b0);
    wr(2'd0, 13'h0007, 16'h1234, 1'b1, 1'b0);
    rd(2'd0, 13'h0007);
    nop(2);
    chk("mask_low.data", dq_out, 16'h12FF);
    nop(1);

    // Error flags: closed-bank read, double ACT, REF with a bank open, WRITE with data disabled.
    rd(2'd2, 13'h0001);
    nop(3);
    chk("closed_rd.err", err, 7'b0000001);
    act(2'd0, 13'h0006);
    chk("double_act.err", err, 7'b0000011);
    cmd(C_REF, 2'd0, 13'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ref_open.err3", err[3], 1'b1);
    cmd(C_WR, 2'd0, 13'h0002, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wr_no_en.err6", err[6], 1'b1);
    check_state("errs");

    // ACT before any MRS.
    reset_cycle();
    act(2'd3, 13'h0001);
    chk("act_no_mrs.err", err, 7'b0000100);

    // Randomized traffic with CL changes while reads are in flight.
    reset_cycle();
    mrs({6'd0, ($urandom_range(0, 1) == 0) ? 3'd2 : 3'd3, 4'd0});
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 110; i++) begin
        b = 2'($urandom_range(0, 3));
        r = $urandom_range(0, 99);
        a = {3'd0, ($urandom_range(0, 9) == 0), 5'd0, 4'($urandom_range(0, 15))};
        if (r < 5) begin
          cmd(3'($urandom_range(0, 7)), b, a, 16'($urandom), 1'b0, 1'b0, 1'b1, 1'b1);
        end else if (!m_open[b]) begin
          act(b, 13'($urandom_range(0, 7)));
        end else if (r < 45) begin
          wr(b, a, 16'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
        end else if (r < 80) begin
          rd(b, a);
        end else if (r < 88) begin
          cmd(C_PRE, b, a, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end else if (r < 90) begin
          mrs({6'd0, ($urandom_range(0, 1) == 0) ? 3'd2 : 3'd3, 4'd0});
        end else begin
          nop(1);
        end
      end
      cmd(C_PRE, 2'd0, 13'h0400, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      nop(3);
      cmd(C_REF, 2'd0, 13'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    nop(4);
    check_state("random");

    // Periodic refresh every 390 cycles for 5000 cycles, then the watchdog limit.
    reset_cycle();
    mrs(13'h030);
    for (int i = 0; i < 5000; i++) begin
      if (i % 390 == 0) cmd(C_REF, 2'd0, 13'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      else nop(1);
    end
    check_state("refresh_run");
    chk("refresh_run.count", refresh_count, 16'd13);
    chk("refresh_run.err5", err[5], 1'b0);
    cmd(C_REF, 2'd0, 13'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    nop(512);
    chk("wd512.err5", err[5], 1'b0);
    nop(1);
    chk("wd513.err5", err[5], 1'b1);
    check_state("watchdog");

    // Reset one cycle after a READ edge discards the pending data.
    reset_cycle();
    mrs(13'h030);
    act(2'd3, 13'h0002);
    wr(2'd3, 13'h0001, 16'hBEEF, 1'b0, 1'b0);
    rd(2'd3, 13'h0001);
    reset_cycle();
    check_state("rst_mid_read");
    chk("rst_mid_read.dq_out", dq_out, 16'h0000);
    chk("rst_mid_read.bank_open", bank_open, 4'd0);
    nop(3);
    chk("rst_mid_read.en_after", dq_out_en, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
